// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared FSM encodings, register constants and parameter defaults
// Revision: 1.0
`default_nettype none

package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MAX_INFLIGHT = 3;
  localparam int DEF_FLUSH_CYC    = 1;

endpackage

`default_nettype wire

// File: rtl/sb_counter_file.sv
// sb_counter_file: 31 saturating pending-write counters, one increment and two decrement ports
// Revision: 1.0
`default_nettype none

module sb_counter_file #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [4:0]       inc_idx,
  input  logic             dec0_en,
  input  logic [4:0]       dec0_idx,
  input  logic             dec1_en,
  input  logic [4:0]       dec1_idx,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  input  logic [4:0]       rd_idx,
  output logic [CNT_W-1:0] rs1_cnt,
  output logic [CNT_W-1:0] rs2_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             underflow
);

  logic [CNT_W-1:0] pend     [32];
  logic [CNT_W-1:0] pend_nxt [32];
  logic [31:0]      uf_vec;

  // Entry 0 is never updated, so x0 always reads as zero pending writes.
  always_comb begin
    logic [CNT_W:0] up;
    logic [1:0]     dn;
    logic [CNT_W:0] diff;
    up     = '0;
    dn     = '0;
    diff   = '0;
    uf_vec = '0;
    for (int r = 0; r < 32; r++) begin
      pend_nxt[r] = '0;
      if (r != 0) begin
        up   = {1'b0, pend[r]} + {{CNT_W{1'b0}}, (inc_en && inc_idx == 5'(r))};
        dn   = {1'b0, (dec0_en && dec0_idx == 5'(r))} + {1'b0, (dec1_en && dec1_idx == 5'(r))};
        diff = up - (CNT_W+1)'(dn);
        if ((CNT_W+1)'(dn) > up) begin
          uf_vec[r] = 1'b1;
        end else begin
          pend_nxt[r] = diff[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (!rst_n) pend[r] <= '0;
      else        pend[r] <= pend_nxt[r];
    end
  end

  assign rs1_cnt   = pend[rs1_idx];
  assign rs2_cnt   = pend[rs2_idx];
  assign rd_cnt    = pend[rd_idx];
  assign underflow = |uf_vec;

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue control with RAW/capacity hold, serial drain and redirect flush
// Revision: 1.0
`default_nettype none

module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYC    = DEF_FLUSH_CYC,
  parameter int WB_BYPASS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_used,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rwen,
  input  logic       id_serial,
  output logic       id_ready,
  input  logic       ex_redirect,
  input  logic       kill_valid,
  input  logic [4:0] kill_rd,
  input  logic       kill_rwen,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_rwen,
  output logic       flush_id,
  output logic       stall_if,
  output logic [2:0] inflight,
  output logic       err
);

  localparam logic [2:0] MAX_INF       = 3'(MAX_INFLIGHT);
  localparam int         FLUSH_INIT_I  = (FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0;
  localparam logic [1:0] FLUSH_INIT    = FLUSH_INIT_I[1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       flush_cnt, flush_cnt_nxt;
  logic [2:0]       inflight_nxt;
  logic             inf_uf, pend_uf;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, wb_cnt;
  logic             issue, raw, cap_full, src1_haz, src2_haz;
  logic             wb_hit1, wb_hit2, wb_last;

  sb_counter_file #(.CNT_W(CNT_W)) u_counters (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (issue & id_rwen),
    .inc_idx   (id_rd),
    .dec0_en   (wb_valid & wb_rwen),
    .dec0_idx  (wb_rd),
    .dec1_en   (kill_valid & kill_rwen),
    .dec1_idx  (kill_rd),
    .rs1_idx   (id_rs1),
    .rs2_idx   (id_rs2),
    .rd_idx    (wb_rd),
    .rs1_cnt   (rs1_cnt),
    .rs2_cnt   (rs2_cnt),
    .rd_cnt    (wb_cnt),
    .underflow (pend_uf)
  );

  // A source hit by a writeback that retires its last pending write is already resolved.
  assign wb_last  = (WB_BYPASS != 0) & wb_valid & wb_rwen & (wb_cnt == CNT_ONE);
  assign wb_hit1  = wb_last & (wb_rd == id_rs1);
  assign wb_hit2  = wb_last & (wb_rd == id_rs2);
  assign src1_haz = id_rs1_used & (id_rs1 != REG_ZERO) & (rs1_cnt != '0) & ~wb_hit1;
  assign src2_haz = id_rs2_used & (id_rs2 != REG_ZERO) & (rs2_cnt != '0) & ~wb_hit2;
  assign raw      = src1_haz | src2_haz;
  assign cap_full = (inflight == MAX_INF) & ~(wb_valid | kill_valid);
  assign issue    = id_valid & id_ready;

  always_comb begin
    logic [3:0] up;
    logic [3:0] dn;
    logic [3:0] diff;
    up           = {1'b0, inflight} + {3'b000, issue};
    dn           = {3'b000, wb_valid} + {3'b000, kill_valid};
    diff         = up - dn;
    inf_uf       = 1'b0;
    inflight_nxt = diff[2:0];
    if (dn > up) begin
      inf_uf       = 1'b1;
      inflight_nxt = '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    id_ready      = 1'b0;
    flush_id      = 1'b0;
    case (state)
      ST_RUN: begin
        id_ready = id_valid & ~raw & ~cap_full & ~ex_redirect
                 & ~(id_serial & (inflight != '0));
        if (id_valid & id_serial & (inflight != '0) & ~ex_redirect)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight_nxt == '0) state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nxt = ST_RUN;
        else                 flush_cnt_nxt = flush_cnt - 2'd1;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (ex_redirect) begin
      flush_id      = 1'b1;
      id_ready      = 1'b0;
      state_nxt     = (FLUSH_CYC > 0) ? ST_FLUSH : ST_RUN;
      flush_cnt_nxt = FLUSH_INIT;
    end
    if (!rst_n) begin
      id_ready = 1'b0;
      flush_id = 1'b0;
    end
  end

  assign stall_if = ~rst_n | (id_valid & ~id_ready & ~flush_id);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      inflight  <= inflight_nxt;
      if (inf_uf | pend_uf) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenario tasks against issue_scoreboard with default parameters
// Revision: 1.0
`default_nettype none

module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rwen, id_serial;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_ready, ex_redirect;
  logic       kill_valid, kill_rwen, wb_valid, wb_rwen;
  logic [4:0] kill_rd, wb_rd;
  logic       flush_id, stall_if, err;
  logic [2:0] inflight;

  int vecs = 0;
  int miscmp = 0;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rwen(id_rwen),
    .id_serial(id_serial), .id_ready(id_ready), .ex_redirect(ex_redirect),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_rwen(kill_rwen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rwen(wb_rwen),
    .flush_id(flush_id), .stall_if(stall_if), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_rwen = 0; id_serial = 0; ex_redirect = 0;
    kill_valid = 0; kill_rd = 0; kill_rwen = 0;
    wb_valid = 0; wb_rd = 0; wb_rwen = 0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ser);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rwen = we; id_serial = ser;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd; wb_rwen = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    drive_id(1, 0, 0, 0, 0, 1, 1, 0);
    cyc(); cyc();
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL reset_ready: got %b want 0", id_ready); end
    vecs++; if (flush_id !== 1'b0) begin miscmp++; $display("FAIL reset_flush: got %b want 0", flush_id); end
    vecs++; if (stall_if !== 1'b1) begin miscmp++; $display("FAIL reset_stall: got %b want 1", stall_if); end
    idle(); rst_n = 1; cyc();
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    vecs++; if (err !== 1'b0) begin miscmp++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_raw();
    drive_id(1, 0, 0, 0, 0, 5, 1, 0); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL raw_first_issue: got %b want 1", id_ready); end
    cyc();
    drive_id(1, 5, 1, 0, 0, 6, 1, 0); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL raw_hold: got %b want 0", id_ready); end
    vecs++; if (stall_if !== 1'b1) begin miscmp++; $display("FAIL raw_stall: got %b want 1", stall_if); end
    cyc(); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL raw_hold2: got %b want 0", id_ready); end
    wb(5); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL raw_wb_bypass: got %b want 1", id_ready); end
    cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd1) begin miscmp++; $display("FAIL raw_inflight: got %0d want 1", inflight); end
    wb(6); cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL raw_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_capacity();
    for (int i = 1; i <= 3; i++) begin
      drive_id(1, 0, 0, 0, 0, 5'(i), 1, 0); #1;
      vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL cap_issue%0d: got %b want 1", i, id_ready); end
      cyc();
    end
    drive_id(1, 0, 0, 0, 0, 4, 1, 0); #1;
    vecs++; if (inflight !== 3'd3) begin miscmp++; $display("FAIL cap_inflight: got %0d want 3", inflight); end
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL cap_full_hold: got %b want 0", id_ready); end
    wb(1); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL cap_wb_frees: got %b want 1", id_ready); end
    cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd3) begin miscmp++; $display("FAIL cap_net: got %0d want 3", inflight); end
    for (int i = 2; i <= 4; i++) begin wb(5'(i)); cyc(); end
    idle(); #1;
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL cap_drained: got %0d want 0", inflight); end
  endtask

  task automatic test_serial();
    drive_id(1, 0, 0, 0, 0, 10, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 11, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 0, 0, 1); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL serial_hold: got %b want 0", id_ready); end
    cyc(); wb(10); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL serial_drain1: got %b want 0", id_ready); end
    cyc(); wb(11); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL serial_drain2: got %b want 0", id_ready); end
    cyc(); wb_valid = 0; wb_rwen = 0; #1;
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL serial_inflight: got %0d want 0", inflight); end
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL serial_issue: got %b want 1", id_ready); end
    cyc(); idle();
    wb_valid = 1; cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL serial_retired: got %0d want 0", inflight); end
  endtask

  task automatic test_redirect();
    drive_id(1, 0, 0, 0, 0, 7, 1, 0); ex_redirect = 1; #1;
    vecs++; if (flush_id !== 1'b1) begin miscmp++; $display("FAIL redir_flush: got %b want 1", flush_id); end
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL redir_ready: got %b want 0", id_ready); end
    vecs++; if (stall_if !== 1'b0) begin miscmp++; $display("FAIL redir_stall: got %b want 0", stall_if); end
    cyc(); ex_redirect = 0; #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL redir_bubble: got %b want 0", id_ready); end
    vecs++; if (flush_id !== 1'b0) begin miscmp++; $display("FAIL redir_bubble_flush: got %b want 0", flush_id); end
    vecs++; if (stall_if !== 1'b1) begin miscmp++; $display("FAIL redir_bubble_stall: got %b want 1", stall_if); end
    cyc(); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL redir_resume: got %b want 1", id_ready); end
    cyc();
    drive_id(1, 7, 1, 0, 0, 0, 0, 0);
    kill_valid = 1; kill_rd = 7; kill_rwen = 1; #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL kill_same_cycle: got %b want 0", id_ready); end
    cyc(); kill_valid = 0; kill_rwen = 0; #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL kill_cleared: got %b want 1", id_ready); end
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL kill_inflight: got %0d want 0", inflight); end
    idle();
  endtask

  task automatic test_simultaneous();
    drive_id(1, 0, 0, 0, 0, 9, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 4, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 9, 1, 0); wb(9);
    kill_valid = 1; kill_rd = 4; kill_rwen = 1; #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL sim_issue: got %b want 1", id_ready); end
    cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd1) begin miscmp++; $display("FAIL sim_inflight: got %0d want 1", inflight); end
    drive_id(1, 9, 1, 0, 0, 0, 0, 0); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL sim_pend9_kept: got %b want 0", id_ready); end
    drive_id(1, 0, 0, 4, 1, 0, 0, 0); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL sim_pend4_cleared: got %b want 1", id_ready); end
    drive_id(1, 0, 0, 0, 0, 0, 1, 0); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL x0_write_issue: got %b want 1", id_ready); end
    cyc();
    drive_id(1, 0, 1, 0, 1, 0, 0, 0); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL x0_read: got %b want 1", id_ready); end
    idle(); wb(9); cyc();
    wb(0); cyc(); idle(); #1;
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL x0_inflight: got %0d want 0", inflight); end
    vecs++; if (err !== 1'b0) begin miscmp++; $display("FAIL x0_no_err: got %b want 0", err); end
  endtask

  task automatic test_underflow();
    wb_valid = 1; wb_rd = 3; wb_rwen = 0; cyc(); idle(); #1;
    vecs++; if (err !== 1'b1) begin miscmp++; $display("FAIL uf_err: got %b want 1", err); end
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL uf_saturate: got %0d want 0", inflight); end
    cyc(); cyc(); #1;
    vecs++; if (err !== 1'b1) begin miscmp++; $display("FAIL uf_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_drain();
    drive_id(1, 0, 0, 0, 0, 12, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 13, 1, 0); cyc();
    drive_id(1, 0, 0, 0, 0, 0, 0, 1); cyc(); #1;
    vecs++; if (id_ready !== 1'b0) begin miscmp++; $display("FAIL rd_in_drain: got %b want 0", id_ready); end
    rst_n = 0; #1;
    vecs++; if (stall_if !== 1'b1) begin miscmp++; $display("FAIL rd_reset_stall: got %b want 1", stall_if); end
    cyc(); rst_n = 1; #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL rd_run_after: got %b want 1", id_ready); end
    vecs++; if (inflight !== 3'd0) begin miscmp++; $display("FAIL rd_inflight: got %0d want 0", inflight); end
    vecs++; if (err !== 1'b0) begin miscmp++; $display("FAIL rd_err_clear: got %b want 0", err); end
    drive_id(1, 12, 1, 13, 1, 0, 0, 0); #1;
    vecs++; if (id_ready !== 1'b1) begin miscmp++; $display("FAIL rd_pend_clear: got %b want 1", id_ready); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_capacity();
    test_serial();
    test_redirect();
    test_simultaneous();
    test_underflow();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order issue controller between ID and EXU.
- Tracks a per-register pending-write count for instructions in flight (EX/MEM/WB) and holds back issue on RAW hazards or capacity exhaustion.
- Drains the pipeline before serializing instructions (CSR writes, fence, ecall/mret).
- Inserts flush bubbles after an EX-resolved branch/jump redirect.

Parameters:
- MAX_INFLIGHT, 3: maximum instructions issued but not yet retired or killed.
- CNT_W, 2: width of each per-register pending counter; must hold MAX_INFLIGHT.
- FLUSH_CYC, 1: extra bubble cycles held after the redirect cycle (0..3).
- WB_BYPASS, 1: when 1, a same-cycle writeback that clears the last pending write to a register also clears the RAW hazard.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- id_valid  in  1  ID holds a decoded instruction
- id_rs1  in  5  source register 1
- id_rs1_used  in  1  rs1 is read
- id_rs2  in  5  source register 2
- id_rs2_used  in  1  rs2 is read
- id_rd  in  5  destination register
- id_rwen  in  1  instruction writes rd
- id_serial  in  1  instruction requires an empty pipeline
- id_ready  out  1  issue accepted when id_valid & id_ready
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- kill_valid  in  1  an issued instruction is cancelled
- kill_rd  in  5  destination of the cancelled instruction
- kill_rwen  in  1  cancelled instruction had R_wen
- wb_valid  in  1  an instruction retires
- wb_rd  in  5  destination of the retiring instruction
- wb_rwen  in  1  retiring instruction writes rd
- flush_id  out  1  invalidate the IF/ID contents
- stall_if  out  1  freeze the PC and IF/ID register
- inflight  out  3  total in-flight count
- err  out  1  sticky protocol error

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - All pending counters, inflight and the bubble counter clear to 0.
  - FSM goes to RUN; err clears to 0.
  - During reset: id_ready=0, flush_id=0, stall_if=1.
  - Reset asserted mid-drain or mid-flush aborts that operation with no residual state.
- State: pend[1..31], each CNT_W bits. pend[0] is never written and always reads 0.
- RAW hazard (combinational):
  - Source condition: (id_rs1_used & rs1≠0 & pend[rs1]≠0) | (id_rs2_used & rs2≠0 & pend[rs2]≠0).
  - With WB_BYPASS=1, a source whose pend==1 and which matches wb_rd with wb_valid & wb_rwen is not a hazard.
- cap_full = (inflight==MAX_INFLIGHT) & ~(wb_valid|kill_valid).
- FSM states: RUN, DRAIN, FLUSH.
  - RUN: id_ready = id_valid & ~raw & ~cap_full & ~ex_redirect & ~(id_serial & inflight≠0).
    - On id_valid & id_serial & inflight≠0 & ~ex_redirect, go to DRAIN.
  - DRAIN: id_ready=0.
    - When the next-cycle inflight==0, return to RUN; the serial instruction then issues from RUN.
  - FLUSH: id_ready=0; a bubble counter counts down from FLUSH_CYC-1.
    - Return to RUN when the counter reaches 0.
  - ex_redirect in any state:
    - flush_id=1 in that same cycle (combinational) and id_ready=0.
    - Next state is FLUSH if FLUSH_CYC>0, else RUN.
    - ex_redirect has priority over DRAIN.
- stall_if = id_valid & ~id_ready & ~flush_id.
- Counter update (registered, end of cycle):
  - inflight += issue; inflight -= wb_valid; inflight -= kill_valid.
  - For each r≠0: pend[r] += issue&id_rwen&(id_rd==r); pend[r] -= wb_valid&wb_rwen&(wb_rd==r); pend[r] -= kill_valid&kill_rwen&(kill_rd==r).
  - All three events in one cycle are legal; net deltas are summed, so issue and writeback to the same rd leave the count unchanged.
  - Writes to x0 never change pend.
  - wb_valid and kill_valid never name the same instruction; kill never coincides with a wb of the same rd whose pend==1.
- Error handling: a decrement of a zero counter (pend or inflight) sets err; the counter saturates at 0. err stays set until reset.
- An issue while inflight==MAX_INFLIGHT is impossible by construction.

Decomposition:
- Shared package / define file:
  - FSM state encodings ST_RUN, ST_DRAIN, ST_FLUSH (2 bits).
  - The REG_ZERO constant.
  - Defaults for MAX_INFLIGHT and FLUSH_CYC.
- One natural sub-module: sb_counter_file.
  - Holds the 31 CNT_W counters with 1 increment port and 2 decrement ports, plus an underflow flag.
  - Provides 3 combinational read ports (rs1, rs2, rd).
- The FSM and hazard logic stay in issue_scoreboard.

Test Plan:
- RAW, no bypass:
  - Issue rd=5 (rwen) at cycle 0, then id rs1=5 at cycle 1 → id_ready=0 and stall_if=1 until wb_rd=5.
  - With WB_BYPASS=1, id_ready=1 in the writeback cycle.
- Capacity: three back-to-back issues to rd=1,2,3 with no wb → inflight=3, fourth id_ready=0; one wb → id_ready=1 in that same cycle.
- Serializing instruction:
  - With inflight=2 and id_serial=1 → DRAIN and id_ready=0.
  - Two wb pulses bring inflight to 0; id_ready=1 the following cycle.
- Redirect:
  - ex_redirect pulse with FLUSH_CYC=1 → flush_id=1 in that cycle, id_ready=0 for 2 cycles total, then RUN.
  - kill_valid, kill_rd=7 → pend[7] returns to 0.
- Simultaneous events and x0:
  - Same cycle: issue rd=9, wb rd=9, kill rd=4 → pend[9] unchanged, pend[4]-1, inflight-1.
  - id_rd=0 with rwen → no pend change; a source reading x0 never stalls.
- Underflow and reset:
  - wb_valid with inflight=0 → err=1 (sticky), inflight stays 0.
  - Assert rst_n=0 during DRAIN → RUN, all counts 0, err=0.
